// File: rtl/sonic_gearbox_pkg.sv
// Shared types and constants for the 66b-in / 40b-out TX gearbox.
package sonic_gearbox_pkg;

    localparam int unsigned GB_BLK_W           = 66;
    localparam int unsigned GB_WORD_W          = 40;
    localparam int unsigned GB_CNT_W           = 7;
    localparam int unsigned GB_PERIOD          = 33;
    localparam int unsigned GB_BLKS_PER_PERIOD = 20;

    // Merge width: a full block stacked on the largest residual that still requests one.
    localparam int unsigned GB_COMB_W          = GB_BLK_W + GB_WORD_W;
    localparam int unsigned GB_CNT_MAX         = GB_BLK_W - 1;
    localparam int unsigned GB_STAT_W          = 32;

    typedef logic [GB_BLK_W-1:0]  gb_blk_t;
    typedef logic [GB_WORD_W-1:0] gb_word_t;
    typedef logic [GB_COMB_W-1:0] gb_comb_t;
    typedef logic [GB_CNT_W-1:0]  gb_cnt_t;

    // Registered output beat towards the PMA.
    typedef struct packed {
        gb_word_t data;
        logic     valid;
    } gb_beat_t;

    // Priming state: underflow is only meaningful once a block has been taken.
    typedef enum logic {
        GB_ST_IDLE   = 1'b0,
        GB_ST_PRIMED = 1'b1
    } gb_state_e;

    // Mask selecting the lowest n bits of a block-wide vector.
    function automatic gb_blk_t gb_low_mask(input gb_cnt_t n);
        gb_blk_t m;
        for (int i = 0; i < GB_BLK_W; i++) begin
            m[i] = (GB_CNT_W'(i) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/sonic_gearbox_66_40_if.sv
// Encoder-side block handshake and PMA-side word stream of the TX gearbox.
interface sonic_gearbox_66_40_if;
    import sonic_gearbox_pkg::*;

    gb_blk_t  data_in;
    logic     data_in_valid;
    logic     data_req;
    gb_word_t data_out;
    logic     data_out_valid;
    logic     underflow;

    // Encoder / test side.
    modport master (
        output data_in,
        output data_in_valid,
        input  data_req,
        input  data_out,
        input  data_out_valid,
        input  underflow
    );

    // Gearbox side.
    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_req,
        output data_out,
        output data_out_valid,
        output underflow
    );
endinterface

// File: rtl/sonic_gearbox_tx_merge.sv
// Combinational merge of the residual bits with an incoming block (the only variable shifter).
module sonic_gearbox_tx_merge
    import sonic_gearbox_pkg::*;
(
    input  gb_blk_t  res_bits,
    input  gb_cnt_t  cnt,
    input  gb_blk_t  data_in,
    input  logic     acc,
    output gb_comb_t comb,
    output gb_cnt_t  avail
);

    gb_comb_t res_ext;
    gb_comb_t blk_shift;

    // Residual is trimmed to its valid bits so nothing stale leaks above cnt.
    always_comb begin
        res_ext   = GB_COMB_W'(res_bits & gb_low_mask(cnt));
        blk_shift = GB_COMB_W'(data_in) << cnt;
    end

    // New block lands directly above the residual, LSB first.
    always_comb begin
        comb  = res_ext;
        avail = cnt;
        if (acc) begin
            comb  = res_ext | blk_shift;
            avail = cnt + GB_CNT_W'(GB_BLK_W);
        end
    end

endmodule

// File: rtl/sonic_gearbox_66_40.sv
// TX gearbox: pulls 66-bit blocks, emits one 40-bit word per PMA clock, LSB first.
// Optional build macro SONIC_GEARBOX_TX_STATS_EN adds blk_cnt/word_cnt counters.
module sonic_gearbox_66_40
    import sonic_gearbox_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  reset,
    sonic_gearbox_66_40_if.slave  gb
`ifdef SONIC_GEARBOX_TX_STATS_EN
    ,
    output logic [GB_STAT_W-1:0]  blk_cnt,
    output logic [GB_STAT_W-1:0]  word_cnt
`endif
);

    gb_state_e state_q, state_d;
    gb_blk_t   res_q,   res_d;
    gb_cnt_t   cnt_q,   cnt_d;
    logic      req_q,   req_d;
    gb_beat_t  out_q,   out_d;
    logic      uf_q,    uf_d;

    logic      acc_c;
    gb_comb_t  comb_c;
    gb_cnt_t   avail_c;

    // A block is taken only when the registered request was up.
    always_comb begin
        acc_c = req_q & gb.data_in_valid;
    end

    sonic_gearbox_tx_merge u_merge (
        .res_bits (res_q),
        .cnt      (cnt_q),
        .data_in  (gb.data_in),
        .acc      (acc_c),
        .comb     (comb_c),
        .avail    (avail_c)
    );

    // Next-state: emit a word when 40 bits are available, otherwise hold and flag underflow.
    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        out_d.valid = 1'b0;
        uf_d      = uf_q;
        req_d     = 1'b0;

        if (avail_c >= GB_CNT_W'(GB_WORD_W)) begin
            out_d.data  = comb_c[GB_WORD_W-1:0];
            out_d.valid = 1'b1;
            res_d       = GB_BLK_W'(comb_c >> GB_WORD_W);
            cnt_d       = avail_c - GB_CNT_W'(GB_WORD_W);
        end else begin
            res_d = comb_c[GB_BLK_W-1:0];
            cnt_d = avail_c;
            if (state_q == GB_ST_PRIMED) begin
                uf_d = 1'b1;
            end
        end

        req_d = (cnt_d < GB_CNT_W'(GB_WORD_W));

        case (state_q)
            GB_ST_IDLE:   if (acc_c) state_d = GB_ST_PRIMED;
            GB_ST_PRIMED: state_d = GB_ST_PRIMED;
            default:      state_d = GB_ST_IDLE;
        endcase
    end

    // State register; reset drops everything immediately.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= GB_ST_IDLE;
            res_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            out_q   <= '0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            out_q   <= out_d;
            uf_q    <= uf_d;
        end
    end

    // Drive the interface from the registered state.
    assign gb.data_req       = req_q;
    assign gb.data_out       = out_q.data;
    assign gb.data_out_valid = out_q.valid;
    assign gb.underflow      = uf_q;

`ifdef SONIC_GEARBOX_TX_STATS_EN
    // Free-running accept and word counters, wrapping silently.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            blk_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            if (acc_c) begin
                blk_cnt <= blk_cnt + GB_STAT_W'(1);
            end
            if (out_d.valid) begin
                word_cnt <= word_cnt + GB_STAT_W'(1);
            end
        end
    end
`endif

    // Residual can never exceed one block minus a bit.
    cnt_range_a: assert property (@(posedge clk_in) disable iff (reset)
        cnt_q <= GB_CNT_W'(GB_CNT_MAX))
        else $error("gearbox residual count out of range: %0d", cnt_q);

endmodule

// File: tb/tb_sonic_gearbox_66_40.sv
// Self-checking bench for sonic_gearbox_66_40 against a bit-queue reference model.
module tb_sonic_gearbox_66_40;
    import sonic_gearbox_pkg::*;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_in = ~clk_in;

    sonic_gearbox_66_40_if gb_if ();

`ifdef SONIC_GEARBOX_TX_STATS_EN
    logic [31:0] blk_cnt;
    logic [31:0] word_cnt;
`endif

    sonic_gearbox_66_40 dut (
        .clk_in (clk_in),
        .reset  (reset),
        .gb     (gb_if)
`ifdef SONIC_GEARBOX_TX_STATS_EN
        ,
        .blk_cnt  (blk_cnt),
        .word_cnt (word_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    gb_blk_t blk_mem [0:2047];

    // Reference model: a plain FIFO of bits.
    bit          mq[$];
    bit          in_bits[$];
    bit          out_bits[$];
    logic        m_req;
    logic        m_valid;
    logic        m_uf;
    logic        m_primed;
    gb_word_t    m_out;
    int unsigned m_blks;
    int unsigned m_words;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        in_bits.delete();
        out_bits.delete();
        m_req    = 1'b0;
        m_valid  = 1'b0;
        m_uf     = 1'b0;
        m_primed = 1'b0;
        m_out    = '0;
        m_blks   = 0;
        m_words  = 0;
    endtask

    task automatic model_step();
        bit acc;
        acc = m_req && (gb_if.data_in_valid === 1'b1);
        if (acc) begin
            for (int i = 0; i < 66; i++) begin
                mq.push_back(gb_if.data_in[i]);
                in_bits.push_back(gb_if.data_in[i]);
            end
            m_blks++;
        end
        if (mq.size() >= 40) begin
            for (int i = 0; i < 40; i++) m_out[i] = mq.pop_front();
            m_valid = 1'b1;
            m_words++;
        end else begin
            m_valid = 1'b0;
            if (m_primed) m_uf = 1'b1;
        end
        m_req    = (mq.size() < 40);
        m_primed = m_primed | acc;
    endtask

    task automatic compare();
        chk("data_req",       66'(gb_if.data_req),       66'(m_req));
        chk("data_out_valid", 66'(gb_if.data_out_valid), 66'(m_valid));
        chk("data_out",       66'(gb_if.data_out),       66'(m_out));
        chk("underflow",      66'(gb_if.underflow),      66'(m_uf));
`ifdef SONIC_GEARBOX_TX_STATS_EN
        chk("blk_cnt",  66'(blk_cnt),  66'(m_blks));
        chk("word_cnt", 66'(word_cnt), 66'(m_words));
`endif
        if (gb_if.data_out_valid === 1'b1)
            for (int i = 0; i < 40; i++) out_bits.push_back(gb_if.data_out[i]);
    endtask

    task automatic tick();
        @(posedge clk_in);
        if (reset) model_reset();
        else       model_step();
        @(negedge clk_in);
        compare();
    endtask

    // mode 0: always valid; 1: random valid; 2: valid with all-ones garbage while not requested
    task automatic drive(input int mode);
        gb_if.data_in = blk_mem[m_blks % 2048];
        case (mode)
            1:       gb_if.data_in_valid = ($urandom_range(0, 3) != 0);
            2: begin
                gb_if.data_in_valid = 1'b1;
                if (!m_req) gb_if.data_in = 66'h3_FFFF_FFFF_FFFF_FFFF;
            end
            default: gb_if.data_in_valid = 1'b1;
        endcase
    endtask

    task automatic run(input int n, input int mode);
        repeat (n) begin
            drive(mode);
            tick();
        end
    endtask

    task automatic stream_check(input string name);
        int diff;
        diff = 0;
        for (int i = 0; i < out_bits.size(); i++)
            if (i >= in_bits.size() || out_bits[i] != in_bits[i]) diff++;
        chk(name, 66'(diff), 66'(0));
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(0);
        tick();
    endtask

    task automatic fill_random();
        for (int k = 0; k < 2048; k++)
            blk_mem[k] = {2'($urandom), $urandom, $urandom};
    endtask

    // Wait (bounded) until the model residual hits a value with request high.
    task automatic wait_residual(input int target, input string name);
        int n;
        n = 0;
        while (!(mq.size() == target && m_req) && n < 200) begin
            drive(0);
            tick();
            n++;
        end
        chk(name, 66'(n < 200), 66'(1));
    endtask

    // Release from reset and pin the first words with hand-derived values.
    task automatic startup_checks();
        gb_blk_t b0, b1;
        b0 = blk_mem[0];
        b1 = blk_mem[1];
        drive(0);
        reset = 1'b0;
        tick();
        chk("edge1_req",   66'(gb_if.data_req),       66'(1));
        chk("edge1_valid", 66'(gb_if.data_out_valid), 66'(0));
        drive(0); tick();
        chk("word0",  66'(gb_if.data_out), 66'(b0[39:0]));
        chk("cnt_26", 66'(mq.size()),      66'(26));
        drive(0); tick();
        chk("word1",  66'(gb_if.data_out), 66'({b1[13:0], b0[65:40]}));
        chk("cnt_52", 66'(mq.size()),      66'(52));
        chk("req_lo", 66'(gb_if.data_req), 66'(0));
        drive(0); tick();
        chk("word2",  66'(gb_if.data_out), 66'(b1[53:14]));
        chk("cnt_12", 66'(mq.size()),      66'(12));
        chk("valid2", 66'(gb_if.data_out_valid), 66'(1));
        run(63, 0);
`ifdef SONIC_GEARBOX_TX_STATS_EN
        chk("stats_blk_66",  66'(blk_cnt),  66'(40));
        chk("stats_word_66", 66'(word_cnt), 66'(66));
`endif
    endtask

    initial begin
        int nacc, nval, n;
        gb_if.data_in       = '0;
        gb_if.data_in_valid = 1'b0;
        model_reset();
        fill_random();

        // Reset state and power-up sequence.
        @(negedge clk_in);
        tick();
        chk("rst_req",   66'(gb_if.data_req),  66'(0));
        chk("rst_out",   66'(gb_if.data_out),  66'(0));
        chk("rst_uf",    66'(gb_if.underflow), 66'(0));
        startup_checks();

        // Any 33-cycle steady-state window takes 20 blocks and emits 33 words.
        nacc = 0;
        nval = 0;
        repeat (GB_PERIOD) begin
            drive(0);
            if (gb_if.data_req && gb_if.data_in_valid) nacc++;
            tick();
            if (gb_if.data_out_valid) nval++;
        end
        chk("window_accepts", 66'(nacc), 66'(GB_BLKS_PER_PERIOD));
        chk("window_words",   66'(nval), 66'(GB_PERIOD));
        stream_check("stream_s1");

        // 1000 incrementing blocks, always valid.
        for (int k = 0; k < 2048; k++) blk_mem[k] = 66'(k) | (66'(k) << 40);
        apply_reset();
        reset = 1'b0;
        n = 0;
        while (m_blks < 1000 && n < 2000) begin
            drive(0);
            tick();
            n++;
        end
        chk("inc_1000_done", 66'(m_blks >= 1000), 66'(1));
        chk("inc_no_uf",     66'(gb_if.underflow), 66'(0));
        chk("inc_out_len",   66'(out_bits.size() >= 1000 * 66 - 65), 66'(1));
        stream_check("stream_inc");

        // One-cycle gap at residual 26: underflow, no bit loss.
        fill_random();
        apply_reset();
        reset = 1'b0;
        run(5, 0);
        wait_residual(26, "reach_cnt26");
        gb_if.data_in_valid = 1'b0;
        tick();
        chk("gap_valid", 66'(gb_if.data_out_valid), 66'(0));
        chk("gap_uf",    66'(gb_if.underflow),      66'(1));
        chk("gap_req",   66'(gb_if.data_req),       66'(1));
        run(200, 0);
        chk("uf_sticky", 66'(gb_if.underflow), 66'(1));
        stream_check("stream_gap");

        // Garbage presented while not requesting must be ignored.
        run(300, 2);
        stream_check("stream_garbage");

        // Asynchronous reset mid-period with underflow set.
        apply_reset();
        reset = 1'b0;
        run(5, 0);
        wait_residual(26, "reach_cnt26_b");
        gb_if.data_in_valid = 1'b0;
        tick();
        n = 0;
        while (mq.size() != 52 && n < 200) begin
            drive(0);
            tick();
            n++;
        end
        chk("reach_cnt52", 66'(n < 200), 66'(1));
        #2 reset = 1'b1;
        #1;
        chk("async_out",   66'(gb_if.data_out),       66'(0));
        chk("async_valid", 66'(gb_if.data_out_valid), 66'(0));
        chk("async_req",   66'(gb_if.data_req),       66'(0));
        chk("async_uf",    66'(gb_if.underflow),      66'(0));
        model_reset();
        tick();
        startup_checks();
        stream_check("stream_restart");

        // Randomised valid pattern.
        run(400, 1);
        stream_check("stream_random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sonic_gearbox_66_40.md
Name: sonic_gearbox_66_40

Overview:
- TX-direction gearbox, the counterpart of the 40-in/66-out RX gearbox.
- Accepts 66-bit encoded blocks from the TX encoder and emits one 40-bit word every clock to the serializer (PMA) interface.
- Bit order is LSB-first: block bit 0 goes out first, in the lowest free output bit.
- Steady state: 20 blocks consumed per 33 output words (20 × 66 = 33 × 40 = 1320 bits).
- Flow control: the gearbox pulls blocks from the encoder with a registered request.

Parameters:
- none. Widths are fixed: 66 in, 40 out.

Ports:
- clk_in  in  1  clock; PMA word clock.
- reset  in  1  asynchronous, active-high.
- data_in  in  66  encoded block; bit 0 is transmitted first.
- data_in_valid  in  1  block present. Accepted only in a cycle where data_req=1.
- data_req  out  1  registered. High means the gearbox accepts a block this cycle.
- data_out  out  40  output word; bit 0 is transmitted first.
- data_out_valid  out  1  data_out holds a fresh word this cycle.
- underflow  out  1  sticky. Set when data_req=1 and no block arrived while the gearbox is primed.

Behaviour:
- State registers:
  - buf[65:0]: residual bits.
  - cnt[6:0]: number of valid residual bits, range 0..65.
  - primed: a first block has been accepted.
  - data_req, data_out, data_out_valid, underflow.
- Reset (asynchronous, immediate): buf=0, cnt=0, primed=0, data_req=0, data_out=0, data_out_valid=0, underflow=0.
- Per clock edge, outside reset:
  - acc = data_req & data_in_valid.
  - avail = cnt + (acc ? 66 : 0).
  - comb[105:0] = buf[cnt-1:0] | (acc ? data_in << cnt : 0).
  - If avail >= 40:
    - data_out <= comb[39:0]; data_out_valid <= 1.
    - buf <= comb >> 40; cnt <= avail - 40.
  - Else:
    - data_out holds its value; data_out_valid <= 0.
    - buf <= comb; cnt <= avail.
    - If primed: underflow <= 1.
  - data_req <= (cnt_next < 40).
  - primed <= primed | acc.
- Latency: a block accepted at edge E contributes to data_out at that same edge. data_out is registered.
- cnt bounds:
  - Max after an accept is 39 + 66 − 40 = 65.
  - Without an accept, cnt ≥ 40 before the edge, so cnt ≤ 25 after it.
  - cnt > 65 is unreachable. An assertion checks it.
- Startup:
  - data_req rises on the first edge after reset release.
  - data_out_valid stays 0 until the first accept.
  - No underflow is flagged before primed=1.
- data_in_valid while data_req=0: ignored. No state change.
- Underflow recovery:
  - Residual bits are preserved; there is no bit loss.
  - data_req stays 1.
  - The stream resumes bit-exact once a block arrives.
- Reset asserted mid-stream: all state drops immediately. The restart sequence is identical to power-up.
- There is no fixed 33-state table. Phase is implied by cnt and takes exactly 33 distinct values per period in steady state.

Optional Feature:
- Macro: SONIC_GEARBOX_TX_STATS_EN.
- Defined:
  - Adds output blk_cnt[31:0]: counts accepted blocks and wraps at 2^32.
  - Adds output word_cnt[31:0]: counts data_out_valid pulses.
  - Both reset to 0 and wrap silently.
- Undefined: neither port nor the counters exist. Core behaviour is identical either way.

Decomposition:
- Shared package sonic_gearbox_pkg holds:
  - GB_BLK_W=66, GB_WORD_W=40, GB_CNT_W=7, GB_PERIOD=33, GB_BLKS_PER_PERIOD=20.
  - typedef gb_blk_t logic[65:0].
  - typedef gb_word_t logic[39:0].
- Natural sub-module: sonic_gearbox_tx_merge. Purely combinational: buf, cnt, data_in, acc → comb, avail. This isolates the variable shift for synthesis review. Registers stay in the top module.

Test Plan:
- Reset release, encoder always valid:
  - data_req=1 at edge 1.
  - First data_out = blk0[39:0].
  - Then {blk1[13:0], blk0[65:40]}, then blk1[53:14]; cnt sequence 26, 52, 12.
  - Exactly 20 accepts in every 33-cycle steady-state window; data_out_valid=1 every cycle.
- Incrementing 66-bit blocks, 1000 blocks, always valid:
  - Concatenated output bitstream equals concatenated input LSB-first.
  - Zero underflow.
- Drop data_in_valid for one cycle when cnt=26 and data_req=1:
  - data_out_valid=0 for that cycle; underflow=1 and stays 1; data_req stays 1.
  - Subsequent output is bit-exact with no lost bits.
- Drive data_in_valid=1 with data_in=66'h3_FFFF_FFFF_FFFF_FFFF while data_req=0: block ignored; output stream unchanged versus a reference model.
- Assert reset mid-period (cnt=52):
  - All outputs 0 immediately; underflow cleared.
  - After release, scenario 1 sequence repeats exactly.
- With SONIC_GEARBOX_TX_STATS_EN, 66 cycles from prime: blk_cnt=40 and word_cnt=66. Without the macro, the build is clean and the ports are absent.
